sprite_plotter: RTL

Draws one fixed-size character sprite into the VGA framebuffer. It walks the sprite ROM in raster order and aligns each returned colour with its screen coordinate across the ROM's one-cycle read latency. It drives the VGA adapter's plot port, skipping transparent and off-screen pixels. It sits between the character/sprite ROM (upstream, addressed by row*SPR_W+col) and the VGA adapter (downstream), and is started by the game controller with a start/busy/done handshake.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/sprite_raster_counter.sv | 52 +++++
 rtl/sprite_plotter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// ============================================================================
// Module      : sprite_pkg
// Description : Shared sprite geometry, screen limits and draw-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int SPR_W    = 5;
    localparam int SPR_H    = 5;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COL_W    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int ADDR_W   = 10;
    localparam int COLOUR_W = 8;

    localparam logic [COLOUR_W-1:0] TRANSPARENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_raster_counter.sv
// ============================================================================
// Module      : sprite_raster_counter
// Description : Raster-order col/row walker with incremental ROM address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_raster_counter
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [COL_W-1:0] c_col_max = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0] c_row_max = ROW_W'(SPR_H - 1);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;

    // Address tracks row*SPR_W+col by stepping alongside the counters.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (step) begin
            r_addr <= r_addr + 1'b1;
            if (r_col == c_col_max) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign col  = r_col;
    assign row  = r_row;
    assign addr = r_addr;
    assign last = (r_col == c_col_max) && (r_row == c_row_max);

endmodule

`default_nettype wire

// File: rtl/sprite_plotter.sv
// ============================================================================
// Module      : sprite_plotter
// Description : Streams one sprite from ROM to the VGA plot port with clipping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      origin_x,
    input  logic [Y_W-1:0]      origin_y,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                done
);

    localparam logic [X_W:0] c_scr_w = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] c_scr_h = (Y_W+1)'(SCREEN_H);

    state_t r_state;
    state_t w_next;

    logic w_clear;
    logic w_step;
    logic w_busy;
    logic w_done;
    logic w_last;
    logic r_drain_cnt;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;

    logic [X_W-1:0] r_org_x;
    logic [Y_W-1:0] r_org_y;

    logic             r_s1_valid;
    logic [COL_W-1:0] r_s1_col;
    logic [ROW_W-1:0] r_s1_row;

    logic [X_W:0] w_sum_x;
    logic [Y_W:0] w_sum_y;
    logic         w_clip;
    logic         w_plot;

    logic [X_W-1:0]      r_vga_x;
    logic [Y_W-1:0]      r_vga_y;
    logic [COLOUR_W-1:0] r_vga_colour;
    logic                r_vga_plot;

    sprite_raster_counter u_raster (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .step  (w_step),
        .col   (w_col),
        .row   (w_row),
        .addr  (rom_addr),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        w_step  = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DRAIN;
                end else begin
                    w_step = 1'b1;
                end
            end
            DRAIN: begin
                if (r_drain_cnt) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Second DRAIN cycle lets the final ROM word clear the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain_cnt <= 1'b0;
        end else if (r_state == DRAIN) begin
            r_drain_cnt <= ~r_drain_cnt;
        end else begin
            r_drain_cnt <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_org_x <= '0;
            r_org_y <= '0;
        end else if (w_clear) begin
            r_org_x <= origin_x;
            r_org_y <= origin_y;
        end
    end

    // Delay the coordinate one stage so it meets the ROM word it addressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
        end else begin
            r_s1_valid <= (r_state == RUN);
            r_s1_col   <= w_col;
            r_s1_row   <= w_row;
        end
    end

    assign w_sum_x = {1'b0, r_org_x} + (X_W+1)'(r_s1_col);
    assign w_sum_y = {1'b0, r_org_y} + (Y_W+1)'(r_s1_row);

    // Carry-out counts as off-screen so pixels never wrap to the far edge.
    assign w_clip = w_sum_x[X_W] || (w_sum_x >= c_scr_w) ||
                    w_sum_y[Y_W] || (w_sum_y >= c_scr_h);
    assign w_plot = r_s1_valid && (rom_data != TRANSPARENT) && !w_clip;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_vga_x      <= w_sum_x[X_W-1:0];
            r_vga_y      <= w_sum_y[Y_W-1:0];
            r_vga_colour <= rom_data;
            r_vga_plot   <= w_plot;
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;
    assign busy       = w_busy;
    assign done       = w_done;

endmodule

`default_nettype wire
